// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, drives a sync-read instruction memory,
// resolves next-PC from decode control and hands a registered word to decode.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             freezes fetch and decode-facing registers
//   imem_addr         byte address issued to instruction memory this cycle
//   imem_rdata        data for the address issued on the previous cycle
//   jump, jump_addr   J/JAL taken in decode and its 26-bit target field
//   jump_reg, jr_target  JR taken in decode and its register value
//   branch_taken, branch_imm  resolved branch and its 16-bit immediate
//   Instructions      word presented to decode (0 when invalid)
//   instr_valid       Instructions/pc_out hold a real instruction
//   pc_out, pc_plus4  address of Instructions and that address + 4
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] Instructions,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_rd_pc;
  logic        r_rd_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jr_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_br_tgt;
  logic [31:0] w_target;
  logic        w_redirect;

  assign w_pc_plus4 = r_pc_out + 32'd4;
  assign w_jr_tgt   = jr_target & ~32'h3;
  assign w_j_tgt    = {w_pc_plus4[31:28], jump_addr, 2'b00};
  assign w_br_tgt   = w_pc_plus4 +
                      {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Bubbles never redirect; a stalled redirect waits for release.
  assign w_redirect = r_valid & ~stall &
                      (jump_reg | jump | branch_taken);

  always_comb begin
    w_target = w_br_tgt;
    if (jump_reg)  w_target = w_jr_tgt;
    else if (jump) w_target = w_j_tgt;
  end

  // While stalled, re-read the pending word so its data is not lost.
  always_comb begin
    imem_addr = r_fetch_pc;
    if (stall)           imem_addr = r_rd_pc;
    else if (w_redirect) imem_addr = w_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_pc    <= RESET_PC;
      r_rd_valid <= 1'b0;
      r_instr    <= '0;
      r_pc_out   <= '0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      if (w_redirect) begin
        r_instr    <= '0;
        r_valid    <= 1'b0;
        r_rd_pc    <= w_target;
        r_rd_valid <= 1'b1;
        r_fetch_pc <= w_target + 32'd4;
      end else begin
        r_instr    <= r_rd_valid ? imem_rdata : '0;
        r_pc_out   <= r_rd_pc;
        r_valid    <= r_rd_valid;
        r_rd_pc    <= r_fetch_pc;
        r_rd_valid <= 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  assign Instructions = r_instr;
  assign instr_valid  = r_valid;
  assign pc_out       = r_pc_out;
  assign pc_plus4     = w_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, stall,
// redirects with priority, address wrap and mid-run reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] imem_addr, imem_rdata;
  logic        jump, jump_reg, branch_taken;
  logic [25:0] jump_addr;
  logic [31:0] jr_target;
  logic [15:0] branch_imm;
  logic [31:0] instr, pc_out, pc4;
  logic        valid;

  logic        w_reset;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
  logic        w_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Sync-read memory: word at byte address a is 0x2000_0000 + a/4.
  always @(posedge clk) imem_rdata <= 32'h2000_0000 + (imem_addr >> 2);
  always @(posedge clk) w_rdata    <= 32'h2000_0000 + (w_addr >> 2);

  instruction_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .jump(jump), .jump_addr(jump_addr),
    .jump_reg(jump_reg), .jr_target(jr_target),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .Instructions(instr), .instr_valid(valid),
    .pc_out(pc_out), .pc_plus4(pc4)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0),
    .imem_addr(w_addr), .imem_rdata(w_rdata),
    .jump(1'b0), .jump_addr(26'h0),
    .jump_reg(1'b0), .jr_target(32'h0),
    .branch_taken(1'b0), .branch_imm(16'h0),
    .Instructions(w_instr), .instr_valid(w_valid),
    .pc_out(w_pc), .pc_plus4(w_pc4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset_run();
    reset = 1'b1; stall = 1'b0;
    jump = 1'b0; jump_reg = 1'b0; branch_taken = 1'b0;
    jump_addr = '0; jr_target = '0; branch_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%h exp=0", valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", instr); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
    n_checks++; if (pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4 got=%h exp=4", pc4); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL e1_valid got=%h exp=0", valid); end
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL e1_addr got=%h exp=4", imem_addr); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL e2_valid got=%h exp=1", valid); end
    n_checks++; if (instr !== 32'h2000_0000) begin n_fail++; $display("FAIL e2_instr got=%h exp=20000000", instr); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL e2_pc got=%h exp=0", pc_out); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL e2_addr got=%h exp=8", imem_addr); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      n_checks++; if (pc_out !== 32'(4 * i)) begin n_fail++; $display("FAIL run_pc got=%h exp=%h", pc_out, 4 * i); end
      n_checks++; if (instr !== 32'h2000_0000 + 32'(i)) begin n_fail++; $display("FAIL run_instr got=%h exp=%h", instr, 32'h2000_0000 + 32'(i)); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got=%h exp=1", valid); end
    end
  endtask

  // Entered with pc_out=0x08 presented.
  task automatic test_stall();
    stall = 1'b1;
    #1;
    n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_addr0 got=%h exp=c", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_pc got=%h exp=8", pc_out); end
      n_checks++; if (instr !== 32'h2000_0002) begin n_fail++; $display("FAIL stall_instr got=%h exp=20000002", instr); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got=%h exp=1", valid); end
      n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_addr got=%h exp=c", imem_addr); end
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL rel_pc got=%h exp=c", pc_out); end
    n_checks++; if (instr !== 32'h2000_0003) begin n_fail++; $display("FAIL rel_instr got=%h exp=20000003", instr); end
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL rel2_pc got=%h exp=10", pc_out); end
    n_checks++; if (instr !== 32'h2000_0004) begin n_fail++; $display("FAIL rel2_instr got=%h exp=20000004", instr); end
  endtask

  // Entered with pc_out=0x10; branch is held across a stall first.
  task automatic test_branch();
    stall = 1'b1; branch_taken = 1'b1; branch_imm = 16'hFFFC;
    #1;
    n_checks++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL brst_addr got=%h exp=14", imem_addr); end
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL brst_pc got=%h exp=10", pc_out); end
    stall = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL br_addr got=%h exp=4", imem_addr); end
    @(negedge clk);
    branch_taken = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble got=%h exp=0", valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL br_binstr got=%h exp=0", instr); end
    jump = 1'b1; jump_addr = 26'h3FF_FFFF;
    #1;
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL bub_noredir got=%h exp=8", imem_addr); end
    jump = 1'b0;
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL br_pc got=%h exp=4", pc_out); end
    n_checks++; if (instr !== 32'h2000_0001) begin n_fail++; $display("FAIL br_instr got=%h exp=20000001", instr); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL br_valid got=%h exp=1", valid); end
  endtask

  // Entered with pc_out=0x04 valid.
  task automatic test_jump();
    jump_reg = 1'b1; jr_target = 32'h3000_0023;
    #1;
    n_checks++; if (imem_addr !== 32'h3000_0020) begin n_fail++; $display("FAIL jr_addr got=%h exp=30000020", imem_addr); end
    @(negedge clk);
    jump_reg = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL jr_bubble got=%h exp=0", valid); end
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h3000_0020) begin n_fail++; $display("FAIL jr_pc got=%h exp=30000020", pc_out); end
    n_checks++; if (instr !== 32'h2C00_0008) begin n_fail++; $display("FAIL jr_instr got=%h exp=2c000008", instr); end
    n_checks++; if (pc4 !== 32'h3000_0024) begin n_fail++; $display("FAIL jr_pc4 got=%h exp=30000024", pc4); end
    jump = 1'b1; jump_addr = 26'h40;
    jump_reg = 1'b1; jr_target = 32'h0000_0103;
    branch_taken = 1'b1; branch_imm = 16'h0001;
    #1;
    n_checks++; if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL prio_jr got=%h exp=100", imem_addr); end
    jump_reg = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h3000_0100) begin n_fail++; $display("FAIL prio_j got=%h exp=30000100", imem_addr); end
    jump = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h3000_0028) begin n_fail++; $display("FAIL prio_br got=%h exp=30000028", imem_addr); end
    branch_taken = 1'b0; jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL j_bubble got=%h exp=0", valid); end
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h3000_0100) begin n_fail++; $display("FAIL j_pc got=%h exp=30000100", pc_out); end
    n_checks++; if (instr !== 32'h2C00_0040) begin n_fail++; $display("FAIL j_instr got=%h exp=2c000040", instr); end
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h3000_0104) begin n_fail++; $display("FAIL j_seq got=%h exp=30000104", pc_out); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%h exp=0", valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL mid_instr got=%h exp=0", instr); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_addr got=%h exp=0", imem_addr); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (valid !== 1'b1 || pc_out !== 32'h0) begin n_fail++; $display("FAIL mid_restart got=%h/%h exp=1/0", valid, pc_out); end
    n_checks++; if (instr !== 32'h2000_0000) begin n_fail++; $display("FAIL mid_rinstr got=%h exp=20000000", instr); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    w_reset = 1'b0;
    @(negedge clk);
    n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_e1 got=%h exp=0", w_valid); end
    @(negedge clk);
    n_checks++; if (w_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", w_pc); end
    n_checks++; if (w_instr !== 32'h5FFF_FFFE) begin n_fail++; $display("FAIL wrap_i0 got=%h exp=5ffffffe", w_instr); end
    @(negedge clk);
    n_checks++; if (w_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", w_pc); end
    n_checks++; if (w_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=0", w_pc4); end
    @(negedge clk);
    n_checks++; if (w_pc !== 32'h0 || w_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pc2 got=%h/%h exp=0/1", w_pc, w_valid); end
    n_checks++; if (w_instr !== 32'h2000_0000) begin n_fail++; $display("FAIL wrap_i2 got=%h exp=20000000", w_instr); end
  endtask

  initial begin
    w_reset = 1'b1;
    test_reset_run();
    test_stall();
    test_branch();
    test_jump();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage of the single-issue MIPS datapath, directly upstream of instructionwrapper.
- Owns the PC and drives a synchronous-read instruction memory.
- Presents a registered 32-bit instruction with its PC and a valid bit to decode.
- Resolves next-PC (sequential, branch, jump, jump-register) from decode-stage control, inserting one bubble per taken redirect (no delay slot).

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetched instruction (low 2 bits must be 0).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  freeze fetch and decode outputs (downstream hazard)
imem_addr  output  32  byte address issued to instruction memory this cycle
imem_rdata  input  32  memory data for the address issued on the previous cycle
jump  input  1  J/JAL in decode is taken
jump_addr  input  26  J-type target field of the decode instruction
jump_reg  input  1  JR in decode is taken
jr_target  input  32  register value for JR
branch_taken  input  1  resolved BEQ/BNE outcome for the decode instruction
branch_imm  input  16  I-type immediate of the decode instruction
Instructions  output  32  instruction presented to decode (0 when invalid)
instr_valid  output  1  Instructions/pc_out hold a real instruction
pc_out  output  32  byte address of Instructions
pc_plus4  output  32  pc_out + 4, used as the JAL link value

Behaviour:
- Internal registers:
  - fetch_pc: next sequential address.
  - rd_pc / rd_valid: address and validity of the request whose data arrives this cycle.
  - Output registers: Instructions, pc_out, instr_valid.
- Reset values:
  - fetch_pc = RESET_PC, rd_pc = RESET_PC, rd_valid = 0.
  - Instructions = 0, pc_out = 0, instr_valid = 0.
  - A reset asserted mid-operation discards all in-flight state at that edge.
- redirect = instr_valid & ~stall & (jump_reg | jump | branch_taken). Priority is jump_reg > jump > branch_taken.
- Redirect targets:
  - JR: {jr_target[31:2], 2'b00}; the low bits are forced to 0.
  - J: {pc_plus4[31:28], jump_addr, 2'b00}.
  - Branch: pc_plus4 + (sign_extend(branch_imm) << 2).
- imem_addr (combinational):
  - stall=1: rd_pc (re-reads the pending word so its data is not lost).
  - redirect=1: the redirect target.
  - Otherwise: fetch_pc.
- Clock edge, stall=1: every register holds, and the redirect inputs are ignored.
- Clock edge, stall=0, no redirect:
  - Instructions <= rd_valid ? imem_rdata : 0; pc_out <= rd_pc; instr_valid <= rd_valid.
  - rd_pc <= fetch_pc; rd_valid <= 1; fetch_pc <= fetch_pc + 4.
- Clock edge, stall=0, redirect:
  - Instructions <= 0; instr_valid <= 0 (the wrong-path sequential word is squashed).
  - rd_pc <= target; rd_valid <= 1; fetch_pc <= target + 4.
- Latency:
  - The first valid instruction (RESET_PC) appears on the 2nd rising edge after reset deasserts.
  - Steady state is 1 instruction/cycle.
  - Each taken redirect costs exactly 1 bubble cycle (instr_valid=0).
- A bubble (instr_valid=0) never redirects, even if control inputs are high.
- Arithmetic: all PC math is 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- pc_plus4 is combinational from pc_out. It is 4 (not defined otherwise) when pc_out = 0 after reset.
- Stall and redirect together: stall wins. The redirect is taken on the first non-stalled cycle while the decode instruction is still presented.

Test Plan:
1. Reset-to-run: reset for 2 cycles, RESET_PC=0, memory word[i]=0x2000_0000+i, stall=0 -> imem_addr 0,4,8,...; instr_valid rises on the 2nd edge with Instructions=0x2000_0000, pc_out=0, then pc_out 4,8 with 1 instr/cycle.
2. Taken branch: at pc_out=0x10 assert branch_taken, branch_imm=16'hFFFC -> imem_addr=0x04 that cycle; next cycle instr_valid=0; following cycle pc_out=0x04.
3. Jump/JR priority: at pc_out=0x3000_0020 assert jump (jump_addr=26'h40) and jump_reg (jr_target=0x0000_0103) together -> target 0x0000_0100 (JR wins, low bits cleared); with jump alone the target is 0x3000_0100.
4. Stall: assert stall for 3 cycles at pc_out=0x08 -> Instructions/pc_out/instr_valid frozen and imem_addr=0x0C throughout; after release, pc_out=0x0C then 0x10 with no skipped or duplicated words; a redirect held during the stall is taken only after release.
5. Wrap and reset-mid-run: RESET_PC=0xFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; assert reset while streaming -> the next edge gives instr_valid=0, Instructions=0, imem_addr=RESET_PC.
